// File: rtl/trig_edge_qualify_if.sv
// Signal bundle between the trigger edge qualifier and its driver: ADC sample stream,
// trigger configuration, holdoff handshake and the qualified pulse/counter outputs.
interface trig_edge_qualify_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 32
);
    logic [DATA_W-1:0] adc_data;
    logic              adc_valid;
    logic [DATA_W-1:0] trig_level;
    logic [DATA_W-1:0] trig_hyst;
    logic              trig_slope;
    logic              trig_arm_en;
    logic              trig_holdoff_busy;
    logic              trig_force;
    logic              trig_aft_pul;
    logic              trig_armed;
    logic [CNT_W-1:0]  trig_count;
    logic [CNT_W-1:0]  trig_supp_count;

    modport master (
        output adc_data, adc_valid, trig_level, trig_hyst, trig_slope,
               trig_arm_en, trig_holdoff_busy, trig_force,
        input  trig_aft_pul, trig_armed, trig_count, trig_supp_count
    );

    modport slave (
        input  adc_data, adc_valid, trig_level, trig_hyst, trig_slope,
               trig_arm_en, trig_holdoff_busy, trig_force,
        output trig_aft_pul, trig_armed, trig_count, trig_supp_count
    );
endinterface

// File: rtl/trig_edge_qualify.sv
// Level/hysteresis/slope trigger qualifier feeding the holdoff stage on clk_200M.
// Optional macro TRIG_FORCE_EN adds a forced-fire path from ARM_WAIT/ARMED.
module trig_edge_qualify #(
    parameter int DATA_W = 8,
    parameter int PUL_W  = 4,
    parameter int CNT_W  = 32
) (
    input  logic                 clk_200M,
    input  logic                 rst,
    trig_edge_qualify_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARM_WAIT = 2'd1,
        ARMED    = 2'd2,
        FIRE     = 2'd3
    } state_t;

    localparam logic [3:0] PUL_LAST = 4'(PUL_W - 1);

    logic [DATA_W-1:0] r_adc_data;
    logic              r_adc_valid;
    logic [DATA_W-1:0] r_level;
    logic [DATA_W-1:0] r_hyst;
    logic              r_slope;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_pul_cnt;
    logic [CNT_W-1:0]  r_trig_count;
    logic [CNT_W-1:0]  r_supp_count;

    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_arm_thr;
    logic              w_arm_cond;
    logic              w_fire_cond;
    logic              w_fire_entry;
    logic              w_supp;
    logic              w_force;

    always_ff @(posedge clk_200M) begin
        if (rst) begin
            r_adc_data  <= '0;
            r_adc_valid <= 1'b0;
            r_level     <= '0;
            r_hyst      <= '0;
            r_slope     <= 1'b0;
        end else begin
            r_adc_data  <= bus.adc_data;
            r_adc_valid <= bus.adc_valid;
            r_level     <= bus.trig_level;
            r_hyst      <= bus.trig_hyst;
            r_slope     <= bus.trig_slope;
        end
    end

    // Re-arm threshold saturates so a band wider than the level makes the slope untriggerable.
    always_comb begin
        w_sum       = {1'b0, r_level} + {1'b0, r_hyst};
        w_arm_thr   = '0;
        w_arm_cond  = 1'b0;
        w_fire_cond = 1'b0;
        if (r_slope) begin
            w_arm_thr   = w_sum[DATA_W] ? '1 : w_sum[DATA_W-1:0];
            w_arm_cond  = (r_adc_data > w_arm_thr);
            w_fire_cond = (r_adc_data <= r_level);
        end else begin
            w_arm_thr   = (r_level > r_hyst) ? (r_level - r_hyst) : '0;
            w_arm_cond  = (r_adc_data < w_arm_thr);
            w_fire_cond = (r_adc_data >= r_level);
        end
    end

`ifdef TRIG_FORCE_EN
    assign w_force = bus.trig_force;
`else
    logic w_unused_force;
    assign w_unused_force = bus.trig_force;
    assign w_force        = 1'b0;
`endif

    always_comb begin
        w_next       = r_state;
        w_fire_entry = 1'b0;
        w_supp       = 1'b0;
        case (r_state)
            IDLE: begin
                w_next = ARM_WAIT;
            end
            ARM_WAIT: begin
                if (w_force) begin
                    w_next       = FIRE;
                    w_fire_entry = 1'b1;
                end else if (r_adc_valid && w_arm_cond) begin
                    w_next = ARMED;
                end
            end
            ARMED: begin
                if (w_force) begin
                    w_next       = FIRE;
                    w_fire_entry = 1'b1;
                end else if (r_adc_valid && w_fire_cond) begin
                    if (bus.trig_holdoff_busy) begin
                        w_next = ARM_WAIT;
                        w_supp = 1'b1;
                    end else begin
                        w_next       = FIRE;
                        w_fire_entry = 1'b1;
                    end
                end
            end
            FIRE: begin
                if (r_pul_cnt == PUL_LAST) begin
                    w_next = ARM_WAIT;
                end
            end
            default: w_next = IDLE;
        endcase
        // Disarm wins over everything, truncating a pulse and cancelling any pending count.
        if (!bus.trig_arm_en) begin
            w_next       = IDLE;
            w_fire_entry = 1'b0;
            w_supp       = 1'b0;
        end
    end

    always_ff @(posedge clk_200M) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pul_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_fire_entry) begin
                r_pul_cnt <= '0;
            end else if (r_state == FIRE) begin
                r_pul_cnt <= r_pul_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_200M) begin
        if (rst) begin
            r_trig_count <= '0;
            r_supp_count <= '0;
        end else begin
            if (w_fire_entry) begin
                r_trig_count <= r_trig_count + 1'b1;
            end
            if (w_supp) begin
                r_supp_count <= r_supp_count + 1'b1;
            end
        end
    end

    assign bus.trig_aft_pul    = (r_state == FIRE);
    assign bus.trig_armed      = (r_state == ARMED);
    assign bus.trig_count      = r_trig_count;
    assign bus.trig_supp_count = r_supp_count;

endmodule

// File: tb/tb_trig_edge_qualify.sv
// Directed-vector bench for trig_edge_qualify; expectations follow the behavioural description
// (pulse two cycles after the qualifying sample, PUL_W = 4 cycles wide).
module tb_trig_edge_qualify;

    logic clk_200M = 1'b0;
    logic rst      = 1'b1;
    int   checks   = 0;
    int   errors   = 0;

`ifdef TRIG_FORCE_EN
    localparam logic FORCE_ON = 1'b1;
`else
    localparam logic FORCE_ON = 1'b0;
`endif

    trig_edge_qualify_if #(.DATA_W(8), .CNT_W(32)) bus ();

    trig_edge_qualify #(.DATA_W(8), .PUL_W(4), .CNT_W(32)) dut (
        .clk_200M (clk_200M),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 clk_200M = ~clk_200M;

    task automatic tick();
        @(posedge clk_200M);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic valid);
        bus.adc_data  = data;
        bus.adc_valid = valid;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        rst           = 1'b1;
        bus.adc_valid = 1'b0;
        bus.trig_force = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic setConfig(input logic [7:0] level, input logic [7:0] hyst, input logic slope);
        bus.trig_level = level;
        bus.trig_hyst  = hyst;
        bus.trig_slope = slope;
    endtask

    initial begin
        bus.adc_data          = '0;
        bus.adc_valid         = 1'b0;
        bus.trig_arm_en       = 1'b1;
        bus.trig_holdoff_busy = 1'b0;
        bus.trig_force        = 1'b0;
        setConfig(8'd128, 8'd8, 1'b0);

        rst = 1'b1;
        tick();
        tick();
        checkOutput("reset_pul",   32'(bus.trig_aft_pul), 32'd0);
        checkOutput("reset_armed", 32'(bus.trig_armed),   32'd0);
        checkOutput("reset_count", bus.trig_count,        32'd0);
        checkOutput("reset_supp",  bus.trig_supp_count,   32'd0);
        rst = 1'b0;

        // Rising fire: 100 arms (thr 120), 130 fires
        applyStimulus(8'd100, 1'b1);
        checkOutput("rise_armed_early", 32'(bus.trig_armed), 32'd0);
        applyStimulus(8'd110, 1'b1);
        checkOutput("rise_armed", 32'(bus.trig_armed), 32'd1);
        applyStimulus(8'd125, 1'b1);
        checkOutput("rise_pul_125", 32'(bus.trig_aft_pul), 32'd0);
        applyStimulus(8'd130, 1'b1);
        checkOutput("rise_pul_130", 32'(bus.trig_aft_pul), 32'd0);
        applyStimulus(8'd130, 1'b0);
        checkOutput("rise_count", bus.trig_count, 32'd1);
        checkOutput("rise_pul_0", 32'(bus.trig_aft_pul), 32'd1);
        for (int i = 1; i < 4; i++) begin
            applyStimulus(8'd130, 1'b0);
            checkOutput("rise_pul_hi", 32'(bus.trig_aft_pul), 32'd1);
        end
        applyStimulus(8'd130, 1'b0);
        checkOutput("rise_pul_end", 32'(bus.trig_aft_pul), 32'd0);
        checkOutput("rise_count_hold", bus.trig_count, 32'd1);

        // Hysteresis block: 124 never drops below 120
        doReset();
        applyStimulus(8'd130, 1'b1);
        applyStimulus(8'd124, 1'b1);
        applyStimulus(8'd130, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'd130, 1'b0);
            checkOutput("hyst_pul",   32'(bus.trig_aft_pul), 32'd0);
            checkOutput("hyst_armed", 32'(bus.trig_armed),   32'd0);
        end
        checkOutput("hyst_count", bus.trig_count, 32'd0);

        // Falling with saturated arm threshold (250+10 -> 255)
        doReset();
        setConfig(8'd250, 8'd10, 1'b1);
        applyStimulus(8'd255, 1'b1);
        applyStimulus(8'd200, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'd200, 1'b0);
            checkOutput("fall_sat_pul",   32'(bus.trig_aft_pul), 32'd0);
            checkOutput("fall_sat_armed", 32'(bus.trig_armed),   32'd0);
        end
        setConfig(8'd200, 8'd10, 1'b1);
        applyStimulus(8'd215, 1'b1);
        checkOutput("fall_armed_early", 32'(bus.trig_armed), 32'd0);
        applyStimulus(8'd190, 1'b1);
        checkOutput("fall_armed", 32'(bus.trig_armed), 32'd1);
        applyStimulus(8'd190, 1'b0);
        checkOutput("fall_pul_0", 32'(bus.trig_aft_pul), 32'd1);
        checkOutput("fall_count", bus.trig_count, 32'd1);
        for (int i = 1; i < 4; i++) begin
            applyStimulus(8'd190, 1'b0);
            checkOutput("fall_pul_hi", 32'(bus.trig_aft_pul), 32'd1);
        end
        applyStimulus(8'd190, 1'b0);
        checkOutput("fall_pul_end", 32'(bus.trig_aft_pul), 32'd0);

        // Holdoff suppression, then a clean fire
        doReset();
        setConfig(8'd128, 8'd8, 1'b0);
        applyStimulus(8'd100, 1'b1);
        applyStimulus(8'd140, 1'b1);
        checkOutput("hold_armed", 32'(bus.trig_armed), 32'd1);
        bus.trig_holdoff_busy = 1'b1;
        applyStimulus(8'd140, 1'b0);
        checkOutput("hold_pul",   32'(bus.trig_aft_pul), 32'd0);
        checkOutput("hold_supp",  bus.trig_supp_count,   32'd1);
        checkOutput("hold_armed_clr", 32'(bus.trig_armed), 32'd0);
        checkOutput("hold_count", bus.trig_count,        32'd0);
        bus.trig_holdoff_busy = 1'b0;
        applyStimulus(8'd100, 1'b1);
        applyStimulus(8'd140, 1'b1);
        checkOutput("hold_rearm", 32'(bus.trig_armed), 32'd1);
        applyStimulus(8'd0, 1'b0);
        checkOutput("hold_fire_pul",   32'(bus.trig_aft_pul), 32'd1);
        checkOutput("hold_fire_count", bus.trig_count,        32'd1);
        checkOutput("hold_fire_supp",  bus.trig_supp_count,   32'd1);

        // Disable two cycles into FIRE truncates the pulse
        applyStimulus(8'd0, 1'b0);
        checkOutput("dis_pul_1", 32'(bus.trig_aft_pul), 32'd1);
        bus.trig_arm_en = 1'b0;
        applyStimulus(8'd0, 1'b0);
        checkOutput("dis_pul_cut", 32'(bus.trig_aft_pul), 32'd0);
        checkOutput("dis_armed",   32'(bus.trig_armed),   32'd0);
        checkOutput("dis_count",   bus.trig_count,        32'd1);
        applyStimulus(8'd0, 1'b0);
        checkOutput("dis_pul_stay", 32'(bus.trig_aft_pul), 32'd0);

        // Reset mid-sequence clears counters
        bus.trig_arm_en = 1'b1;
        rst = 1'b1;
        tick();
        checkOutput("rst_count", bus.trig_count,      32'd0);
        checkOutput("rst_supp",  bus.trig_supp_count, 32'd0);
        rst = 1'b0;

        // Force with a constant sample that can never arm
        doReset();
        setConfig(8'd128, 8'd8, 1'b0);
        applyStimulus(8'd128, 1'b1);
        applyStimulus(8'd128, 1'b1);
        bus.trig_force = 1'b1;
        applyStimulus(8'd128, 1'b1);
        bus.trig_force = 1'b0;
        checkOutput("force_pul_0", 32'(bus.trig_aft_pul), 32'(FORCE_ON));
        checkOutput("force_count", bus.trig_count,        32'(FORCE_ON));
        for (int i = 1; i < 4; i++) begin
            applyStimulus(8'd128, 1'b1);
            checkOutput("force_pul_hi", 32'(bus.trig_aft_pul), 32'(FORCE_ON));
        end
        applyStimulus(8'd128, 1'b1);
        checkOutput("force_pul_end", 32'(bus.trig_aft_pul), 32'd0);
        checkOutput("force_count_end", bus.trig_count, 32'(FORCE_ON));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
